// File: rtl/cache_base_pkg.sv
// Shared constants and FSM state encodings for the blocking direct-mapped cache controller.
// The optional statistics counters (CACHE_BASE_CTRL_STATS_EN) use satInc from here.
package cache_base_pkg;

    localparam int NUM_LINES      = 32;
    localparam int WORDS_PER_LINE = 16;
    localparam int TAG_BITS       = 21;
    localparam int INDEX_BITS     = 5;
    localparam int WORD_OFF_BITS  = 4;
    localparam int CNT_BITS       = 5;
    localparam int STATE_BITS     = 4;

    typedef logic [STATE_BITS-1:0] state_t;

    localparam state_t IDLE        = 4'd0;
    localparam state_t TAG_CHECK   = 4'd1;
    localparam state_t WRITE_DATA  = 4'd2;
    localparam state_t WRITE_MEM   = 4'd3;
    localparam state_t WRITE_ACK   = 4'd4;
    localparam state_t REFILL_REQ  = 4'd5;
    localparam state_t REFILL_WAIT = 4'd6;
    localparam state_t REFILL_DONE = 4'd7;
    localparam state_t RESP        = 4'd8;

    // Saturating increment so the statistics never roll over to zero.
    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/cache_valid_array.sv
// Per-line valid bits: cleared together by reset, set one line at a time after a refill.
module cache_valid_array
    import cache_base_pkg::*;
#(
    parameter int LINES = NUM_LINES,
    parameter int IDX_W = INDEX_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_set_en,
    input  logic [IDX_W-1:0] i_set_index,
    input  logic [IDX_W-1:0] i_rd_index,
    output logic             o_rd_valid
);

    logic [LINES-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_set_en) begin
            r_valid[i_set_index] <= 1'b1;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];

endmodule

// File: rtl/cache_base_ctrl.sv
// Control FSM for a blocking, write-through, no-write-allocate direct-mapped cache.
// Define CACHE_BASE_CTRL_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_base_ctrl
    import cache_base_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  proc_req_val,
    output logic                  proc_req_rdy,
    output logic                  proc_resp_val,
    input  logic                  proc_resp_rdy,
    output logic                  mem_req_val,
    input  logic                  mem_req_rdy,
    output logic                  mem_req_write,
    input  logic                  mem_resp_val,
    output logic                  mem_resp_rdy,
    input  logic                  tag_array_match,
    input  logic [INDEX_BITS-1:0] index,
    input  logic                  read,
    output logic                  data_array_r_en,
    output logic                  data_array_w_en,
    output logic                  data_array_write_mux_sel,
    output logic                  tag_array_w_en,
`ifdef CACHE_BASE_CTRL_STATS_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
`endif
    output logic [CNT_BITS-1:0]   received_mem_resp_num
);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_BITS-1:0] r_counter;
    logic                w_valid;
    logic                w_hit;
    logic                w_last_beat;
    logic                w_refill_beat;

    cache_valid_array #(
        .LINES (NUM_LINES),
        .IDX_W (INDEX_BITS)
    ) u_valid (
        .clk         (clk),
        .reset       (reset),
        .i_set_en    (r_state == REFILL_DONE),
        .i_set_index (index),
        .i_rd_index  (index),
        .o_rd_valid  (w_valid)
    );

    assign w_hit         = w_valid & tag_array_match;
    assign w_last_beat   = (r_counter == CNT_BITS'(WORDS_PER_LINE - 1));
    assign w_refill_beat = (r_state == REFILL_WAIT) & mem_resp_val;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:        if (proc_req_val) w_next_state = TAG_CHECK;
            TAG_CHECK: begin
                if (read) w_next_state = w_hit ? RESP : REFILL_REQ;
                else      w_next_state = w_hit ? WRITE_DATA : WRITE_MEM;
            end
            WRITE_DATA:  w_next_state = WRITE_MEM;
            WRITE_MEM:   if (mem_req_rdy) w_next_state = WRITE_ACK;
            WRITE_ACK:   if (mem_resp_val) w_next_state = RESP;
            REFILL_REQ:  if (mem_req_rdy) w_next_state = REFILL_WAIT;
            REFILL_WAIT: if (mem_resp_val) w_next_state = w_last_beat ? REFILL_DONE : REFILL_REQ;
            REFILL_DONE: w_next_state = RESP;
            RESP:        if (proc_resp_rdy) w_next_state = IDLE;
            default:     w_next_state = IDLE;
        endcase
    end

    // The beat counter returns to 0 after the last beat so it idles at 0 outside refills.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_counter <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == TAG_CHECK) begin
                r_counter <= '0;
            end else if (w_refill_beat) begin
                r_counter <= w_last_beat ? '0 : r_counter + CNT_BITS'(1);
            end
        end
    end

    assign proc_req_rdy             = (r_state == IDLE);
    assign proc_resp_val            = (r_state == RESP);
    assign mem_req_val              = (r_state == WRITE_MEM) | (r_state == REFILL_REQ);
    assign mem_req_write            = (r_state == WRITE_MEM);
    assign mem_resp_rdy             = (r_state == WRITE_ACK) | (r_state == REFILL_WAIT);
    assign data_array_r_en          = (r_state == TAG_CHECK) | (r_state == RESP);
    assign data_array_w_en          = (r_state == WRITE_DATA) | w_refill_beat;
    assign data_array_write_mux_sel = w_refill_beat;
    assign tag_array_w_en           = (r_state == REFILL_DONE);
    assign received_mem_resp_num    = r_counter;

`ifdef CACHE_BASE_CTRL_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Every request passes through TAG_CHECK exactly once, so count there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == TAG_CHECK) begin
            if (w_hit) r_hit_count  <= satInc(r_hit_count);
            else       r_miss_count <= satInc(r_miss_count);
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
